// File: rtl/ad568x_pkg.sv
// Shared constants, state encodings and frame helper for the
// AD568x serial DAC writer.
package ad568x_pkg;

    localparam logic [3:0] CMD_WR_UPD = 4'b0011;
    localparam logic [3:0] CMD_WR_IN  = 4'b0001;
    localparam logic [3:0] CMD_UPD    = 4'b0010;

    localparam int FRAME_BITS = 24;
    localparam int DATA_FIELD = 20;

    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_SHIFT,
        FRM_HOLD,
        FRM_GAP
    } frm_state_e;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_WR,
        SEQ_LD
    } seq_state_e;

    function automatic logic [FRAME_BITS-1:0] mk_frame(
        input logic [3:0]            cmd,
        input logic [DATA_FIELD-1:0] field
    );
        return {cmd, field};
    endfunction

endpackage

// File: rtl/ad568x_spi_frame.sv
// Shifts one 24-bit frame out on sclk/mosi/sync_n, then holds
// sync_n high for the inter-frame gap and strobes frame_done.
module ad568x_spi_frame
    import ad568x_pkg::*;
#(
    parameter int CLK_DIV  = 8,
    parameter int SYNC_GAP = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] frame,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  sync_n,
    output logic                  frame_done
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(SYNC_GAP + 1);

    frm_state_e            state_q, state_d;
    logic [DW-1:0]         div_q;
    logic [4:0]            bit_q;
    logic [GW-1:0]         gap_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic                  sclk_q, sync_n_q;
    logic                  div_end, last_bit, gap_end, load;

    assign div_end    = (div_q == DW'(CLK_DIV - 1));
    assign last_bit   = (bit_q == 5'(FRAME_BITS - 1));
    assign gap_end    = (gap_q == GW'(SYNC_GAP - 1));
    assign frame_done = (state_q == FRM_GAP) && gap_end;
    assign load       = start && ((state_q == FRM_IDLE) || frame_done);

    assign sclk   = sclk_q;
    assign sync_n = sync_n_q;
    assign mosi   = shreg_q[FRAME_BITS-1];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= FRM_IDLE;
        else     state_q <= state_d;
    end

    // Next-state: high/low half periods per bit, hold, then gap
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FRM_IDLE:  if (start) state_d = FRM_SHIFT;
            FRM_SHIFT: if (div_end && !sclk_q && last_bit)
                           state_d = FRM_HOLD;
            FRM_HOLD:  if (div_end) state_d = FRM_GAP;
            FRM_GAP:   if (gap_end)
                           state_d = start ? FRM_SHIFT : FRM_IDLE;
            default:   state_d = FRM_IDLE;
        endcase
    end

    // Pin and counter registers; mosi moves only on sclk rising
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b1;
            shreg_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
        end else if (load) begin
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b0;
            shreg_q  <= frame;
            div_q    <= '0;
            bit_q    <= '0;
            gap_q    <= '0;
        end else begin
            unique case (state_q)
                FRM_SHIFT: begin
                    if (div_end) begin
                        div_q <= '0;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                        end else begin
                            sclk_q <= 1'b1;
                            if (!last_bit) begin
                                bit_q   <= bit_q + 5'd1;
                                shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                FRM_HOLD: begin
                    if (div_end) begin
                        div_q    <= '0;
                        sync_n_q <= 1'b1;
                        shreg_q  <= '0;
                        gap_q    <= '0;
                    end else begin
                        div_q <= div_q + DW'(1);
                    end
                end
                FRM_GAP:  gap_q <= gap_end ? '0 : gap_q + GW'(1);
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/ad568x_spi_ctrl.sv
// AD568x nanoDAC write controller: handshake or auto trigger,
// one or two frames per code, and last written code tracking.
module ad568x_spi_ctrl
    import ad568x_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CLK_DIV     = 8,
    parameter int UPDATE_MODE = 0,
    parameter int AUTO_UPDATE = 0,
    parameter int SYNC_GAP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] last_data,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  sync_n
);

    seq_state_e            seq_q, seq_d;
    logic [DATA_WIDTH-1:0] code_q, last_q;
    logic                  done_q, first_q;
    logic                  trigger, start, frame_done, final_done;
    logic [FRAME_BITS-1:0] frame;
    logic [DATA_FIELD-1:0] field;
    logic [3:0]            cmd_first;

    assign field     = DATA_FIELD'(s_data) << (DATA_FIELD - DATA_WIDTH);
    assign cmd_first = (UPDATE_MODE != 0) ? CMD_WR_IN : CMD_WR_UPD;

    assign trigger = (seq_q == SEQ_IDLE) && !rst &&
        ((AUTO_UPDATE != 0) ? ((s_data != last_q) || first_q)
                            : s_valid);

    assign final_done = frame_done &&
        ((seq_q == SEQ_LD) || ((seq_q == SEQ_WR) && (UPDATE_MODE == 0)));

    assign done      = done_q;
    assign last_data = last_q;

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) seq_q <= SEQ_IDLE;
        else     seq_q <= seq_d;
    end

    // Sequencer next-state: write frame, optional LDAC frame
    always_comb begin
        seq_d = seq_q;
        unique case (seq_q)
            SEQ_IDLE: if (trigger) seq_d = SEQ_WR;
            SEQ_WR:   if (frame_done)
                          seq_d = (UPDATE_MODE != 0) ? SEQ_LD : SEQ_IDLE;
            SEQ_LD:   if (frame_done) seq_d = SEQ_IDLE;
            default:  seq_d = SEQ_IDLE;
        endcase
    end

    // Sequencer outputs: handshake and frame launch
    always_comb begin
        s_ready = (seq_q == SEQ_IDLE) && !rst;
        busy    = (seq_q != SEQ_IDLE);
        start   = 1'b0;
        frame   = '0;
        unique case (seq_q)
            SEQ_IDLE: begin
                start = trigger;
                frame = mk_frame(cmd_first, field);
            end
            SEQ_WR: begin
                if (UPDATE_MODE != 0) begin
                    start = frame_done;
                    frame = mk_frame(CMD_UPD, '0);
                end
            end
            default: ;
        endcase
    end

    // Code latch, completion pulse and last written code
    always_ff @(posedge clk) begin
        if (rst) begin
            code_q  <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
            first_q <= 1'b1;
        end else begin
            done_q <= final_done;
            if (trigger) code_q <= s_data;
            if (final_done) begin
                last_q  <= code_q;
                first_q <= 1'b0;
            end
        end
    end

    ad568x_spi_frame #(
        .CLK_DIV  (CLK_DIV),
        .SYNC_GAP (SYNC_GAP)
    ) u_frame (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .frame      (frame),
        .sclk       (sclk),
        .mosi       (mosi),
        .sync_n     (sync_n),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_ad568x_spi_ctrl.sv
// Directed bench for ad568x_spi_ctrl: four instances cover
// direct/LDAC modes, data widths and auto update.
module tb_ad568x_spi_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  vld;
    logic [15:0] d0, d1;
    logic [11:0] d2;
    logic [19:0] d3;
    wire  [3:0]  rdy_w, busy_w, done_w, sclk_w, mosi_w, sync_w;
    wire  [15:0] last0, last1;
    wire  [11:0] last2;
    wire  [19:0] last3;

    always #5 clk = ~clk;

    ad568x_spi_ctrl #(.DATA_WIDTH(16), .CLK_DIV(2), .UPDATE_MODE(0),
                      .AUTO_UPDATE(0), .SYNC_GAP(4)) u0 (
        .clk(clk), .rst(rst), .s_valid(vld[0]), .s_ready(rdy_w[0]),
        .s_data(d0), .busy(busy_w[0]), .done(done_w[0]),
        .last_data(last0), .sclk(sclk_w[0]), .mosi(mosi_w[0]),
        .sync_n(sync_w[0]));

    ad568x_spi_ctrl #(.DATA_WIDTH(16), .CLK_DIV(2), .UPDATE_MODE(1),
                      .AUTO_UPDATE(0), .SYNC_GAP(4)) u1 (
        .clk(clk), .rst(rst), .s_valid(vld[1]), .s_ready(rdy_w[1]),
        .s_data(d1), .busy(busy_w[1]), .done(done_w[1]),
        .last_data(last1), .sclk(sclk_w[1]), .mosi(mosi_w[1]),
        .sync_n(sync_w[1]));

    ad568x_spi_ctrl #(.DATA_WIDTH(12), .CLK_DIV(1), .UPDATE_MODE(0),
                      .AUTO_UPDATE(0), .SYNC_GAP(4)) u2 (
        .clk(clk), .rst(rst), .s_valid(vld[2]), .s_ready(rdy_w[2]),
        .s_data(d2), .busy(busy_w[2]), .done(done_w[2]),
        .last_data(last2), .sclk(sclk_w[2]), .mosi(mosi_w[2]),
        .sync_n(sync_w[2]));

    ad568x_spi_ctrl #(.DATA_WIDTH(20), .CLK_DIV(3), .UPDATE_MODE(0),
                      .AUTO_UPDATE(1), .SYNC_GAP(2)) u3 (
        .clk(clk), .rst(rst), .s_valid(vld[3]), .s_ready(rdy_w[3]),
        .s_data(d3), .busy(busy_w[3]), .done(done_w[3]),
        .last_data(last3), .sclk(sclk_w[3]), .mosi(mosi_w[3]),
        .sync_n(sync_w[3]));

    // Frame monitor: DAC view, samples mosi on sclk falling edges
    logic [23:0] sr[4]         = '{default: '0};
    int          nb[4]         = '{default: 0};
    int          low_cnt[4]    = '{default: 0};
    int          hi_cnt[4]     = '{default: 0};
    int          cur_gap[4]    = '{default: 0};
    int          nfr[4]        = '{default: 0};
    int          ndone[4]      = '{default: 0};
    logic [23:0] fr_log[4][8];
    int          fr_bits[4][8];
    int          fr_low[4][8];
    int          fr_gap[4][8];
    logic [3:0]  prev_sclk     = 4'hF;
    logic [3:0]  prev_sync     = 4'hF;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!sync_w[i]) begin
                if (prev_sync[i]) begin
                    cur_gap[i] = hi_cnt[i];
                    sr[i]      = '0;
                    nb[i]      = 0;
                    low_cnt[i] = 0;
                end
                low_cnt[i]++;
                if (prev_sclk[i] && !sclk_w[i]) begin
                    sr[i] = {sr[i][22:0], mosi_w[i]};
                    nb[i]++;
                end
            end else begin
                if (!prev_sync[i]) begin
                    if (nfr[i] < 8) begin
                        fr_log[i][nfr[i]]  = sr[i];
                        fr_bits[i][nfr[i]] = nb[i];
                        fr_low[i][nfr[i]]  = low_cnt[i];
                        fr_gap[i][nfr[i]]  = cur_gap[i];
                    end
                    nfr[i]++;
                    hi_cnt[i] = 0;
                end
                hi_cnt[i]++;
            end
            if (done_w[i]) ndone[i]++;
            prev_sync[i] = sync_w[i];
            prev_sclk[i] = sclk_w[i];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge after acceptance
    task automatic send(input int i, input string tag);
        int k = 0;
        vld[i] = 1'b1;
        while (!rdy_w[i] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_acc_tmo"}, 32'(k < 2000), 32'd1);
        @(negedge clk);
        vld[i] = 1'b0;
    endtask

    // Returns at the negedge where done is high
    task automatic wait_done(input int i, input string tag);
        int k = 0;
        @(negedge clk);
        while (!done_w[i] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_done_tmo"}, 32'(k < 3000), 32'd1);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        vld = '0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(rdy_w[0]), 32'd0);
        chk("rst_sync",  32'(sync_w[0]), 32'd1);
        chk("rst_sclk",  32'(sclk_w[0]), 32'd1);
        chk("rst_mosi",  32'(mosi_w[0]), 32'd0);
        chk("rst_busy",  32'(busy_w[0]), 32'd0);
        chk("rst_done",  32'(done_w[0]), 32'd0);
        chk("rst_last",  32'(last0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(rdy_w[0]), 32'd1);

        // direct write-and-update, 16 bit
        d0 = 16'hABCD;
        send(0, "t1");
        chk("t1_busy", 32'(busy_w[0]), 32'd1);
        chk("t1_sync", 32'(sync_w[0]), 32'd0);
        chk("t1_sclk", 32'(sclk_w[0]), 32'd1);
        chk("t1_mosi", 32'(mosi_w[0]), 32'd0);
        wait_done(0, "t1");
        chk("t1_ready_done", 32'(rdy_w[0]), 32'd1);
        chk("t1_busy_done",  32'(busy_w[0]), 32'd0);
        @(negedge clk);
        chk("t1_done_1cyc", 32'(done_w[0]), 32'd0);
        chk("t1_frame", 32'(fr_log[0][0]), 32'h3ABCD0);
        chk("t1_bits",  32'(fr_bits[0][0]), 32'd24);
        chk("t1_low",   32'(fr_low[0][0]), 32'd98);
        chk("t1_ndone", 32'(ndone[0]), 32'd1);
        chk("t1_last",  32'(last0), 32'hABCD);

        // input-register write then software LDAC
        d1 = 16'h1234;
        send(1, "t2");
        wait_done(1, "t2");
        @(negedge clk);
        chk("t2_nfr",    32'(nfr[1]), 32'd2);
        chk("t2_frame1", 32'(fr_log[1][0]), 32'h112340);
        chk("t2_frame2", 32'(fr_log[1][1]), 32'h200000);
        chk("t2_bits2",  32'(fr_bits[1][1]), 32'd24);
        chk("t2_gap",    32'(fr_gap[1][1] >= 4), 32'd1);
        chk("t2_ndone",  32'(ndone[1]), 32'd1);
        chk("t2_last",   32'(last1), 32'h1234);

        // 12 bit part, CLK_DIV=1
        d2 = 12'hFFF;
        send(2, "t3");
        wait_done(2, "t3");
        @(negedge clk);
        chk("t3_frame", 32'(fr_log[2][0]), 32'h3FFF00);
        chk("t3_low",   32'(fr_low[2][0]), 32'd49);
        chk("t3_last",  32'(last2), 32'hFFF);

        // auto update, 20 bit: initial zero code already written
        chk("t4_nfr0",   32'(nfr[3]), 32'd1);
        chk("t4_frame0", 32'(fr_log[3][0]), 32'h300000);
        chk("t4_low0",   32'(fr_low[3][0]), 32'd147);
        d3 = 20'h00001;
        @(negedge clk);
        d3 = 20'h00005;
        @(negedge clk);
        d3 = 20'h00001;
        wait_done(3, "t4");
        repeat (200) @(negedge clk);
        chk("t4_nfr",   32'(nfr[3]), 32'd2);
        chk("t4_frame", 32'(fr_log[3][1]), 32'h300001);
        chk("t4_last",  32'(last3), 32'h00001);

        // s_valid held: second code taken in the done cycle
        d0 = 16'h1111;
        vld[0] = 1'b1;
        @(negedge clk);
        d0 = 16'h2222;
        wait_done(0, "t5a");
        chk("t5_ready_done", 32'(rdy_w[0]), 32'd1);
        @(negedge clk);
        chk("t5_busy2", 32'(busy_w[0]), 32'd1);
        vld[0] = 1'b0;
        d0 = 16'h0000;
        wait_done(0, "t5b");
        @(negedge clk);
        chk("t5_frame1", 32'(fr_log[0][1]), 32'h311110);
        chk("t5_frame2", 32'(fr_log[0][2]), 32'h322220);
        chk("t5_gap",    32'(fr_gap[0][2] >= 4), 32'd1);
        chk("t5_last",   32'(last0), 32'h2222);

        // reset after the 10th falling edge aborts the frame
        d0 = 16'h5A5A;
        send(0, "t6");
        k = 0;
        while (nb[0] != 10 && k < 2000) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("t6_edge_tmo", 32'(k < 2000), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_sync", 32'(sync_w[0]), 32'd1);
        chk("t6_sclk", 32'(sclk_w[0]), 32'd1);
        chk("t6_done", 32'(done_w[0]), 32'd0);
        chk("t6_last", 32'(last0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_nfr",   32'(nfr[0]), 32'd4);
        chk("t6_pbits", 32'(fr_bits[0][3]), 32'd10);
        d0 = 16'hC3A5;
        send(0, "t6b");
        wait_done(0, "t6b");
        @(negedge clk);
        chk("t6_frame", 32'(fr_log[0][4]), 32'h3C3A50);
        chk("t6_bits",  32'(fr_bits[0][4]), 32'd24);
        chk("t6_low",   32'(fr_low[0][4]), 32'd98);
        chk("t6_ndone", 32'(ndone[0]), 32'd4);
        chk("t6_last2", 32'(last0), 32'hC3A5);

        // auto instance rewrites its code after the reset
        k = 0;
        while (nfr[3] < 3 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("t6_auto_tmo",   32'(k < 2000), 32'd1);
        chk("t6_auto_frame", 32'(fr_log[3][2]), 32'h300001);
        repeat (5) @(negedge clk);
        chk("t6_auto_last",  32'(last3), 32'h00001);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
